// File: rtl/ahb_downsizer.sv
// ahb_downsizer: splits wide AHB-Lite host transfers into sequential narrow device beats
module ahb_downsizer #(
    parameter int AddrWidth     = 32,
    parameter int HostDataWidth = 64,
    parameter int DevDataWidth  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     hsel_i,
    input  logic [AddrWidth-1:0]     haddr_i,
    input  logic [2:0]               hsize_i,
    input  logic [1:0]               htrans_i,
    input  logic                     hwrite_i,
    input  logic [HostDataWidth-1:0] hwdata_i,
    input  logic                     hready_i,
    output logic                     hreadyout_o,
    output logic [HostDataWidth-1:0] hrdata_o,
    output logic                     hresp_o,
    output logic                     d_hsel_o,
    output logic [AddrWidth-1:0]     d_haddr_o,
    output logic [2:0]               d_hsize_o,
    output logic [1:0]               d_htrans_o,
    output logic                     d_hwrite_o,
    output logic [DevDataWidth-1:0]  d_hwdata_o,
    output logic                     d_hready_o,
    input  logic [DevDataWidth-1:0]  d_hrdata_i,
    input  logic                     d_hreadyout_i,
    input  logic                     d_hresp_i
);
    localparam int Ratio    = HostDataWidth / DevDataWidth;
    localparam int DevSize  = $clog2(DevDataWidth / 8);
    localparam int HostSize = $clog2(HostDataWidth / 8);
    localparam int KW       = Ratio > 1 ? $clog2(Ratio) : 1;
    localparam logic [AddrWidth-1:0] LaneMask = AddrWidth'(Ratio - 1);
    localparam logic [2:0] IDLE = 3'd0, DADDR = 3'd1, DDATA = 3'd2, DONE = 3'd3, ERR1 = 3'd4, ERR2 = 3'd5;

    logic [2:0]               state;
    logic [AddrWidth-1:0]     addr;
    logic [2:0]               size;
    logic                     write;
    logic                     multi;
    logic [KW-1:0]            k;
    logic [KW-1:0]            last;
    logic [KW-1:0]            lane;
    logic [HostDataWidth-1:0] wdata;
    logic [HostDataWidth-1:0] rbuf;
    logic [HostDataWidth-1:0] rdata;
    logic [HostDataWidth-1:0] rmerge;
    logic [AddrWidth-1:0]     size_mask;
    logic [AddrWidth-1:0]     beat_addr;
    logic                     accept;
    logic                     unused_ok;

    assign unused_ok = htrans_i[0];
    assign accept    = hsel_i & hready_i & htrans_i[1] & (state == IDLE | state == DONE);
    assign size_mask = (AddrWidth'(1) << size) - AddrWidth'(1);
    assign beat_addr = multi ? (addr & ~size_mask) + (AddrWidth'(k) << DevSize) : addr;
    assign lane      = multi ? k : KW'((addr >> DevSize) & LaneMask);

    // Single-beat reads are replicated so any host lane sees the device word.
    always_comb begin
        rmerge = multi ? rbuf : {Ratio{d_hrdata_i}};
        if (multi) rmerge[lane*DevDataWidth +: DevDataWidth] = d_hrdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            addr  <= '0;
            size  <= '0;
            write <= 1'b0;
            multi <= 1'b0;
            k     <= '0;
            last  <= '0;
            wdata <= '0;
            rbuf  <= '0;
            rdata <= '0;
        end else begin
            if (state == DADDR && k == '0) wdata <= hwdata_i;
            if (accept) begin
                addr  <= haddr_i;
                size  <= hsize_i;
                write <= hwrite_i;
                multi <= hsize_i > 3'(DevSize);
                last  <= hsize_i > 3'(DevSize) ? KW'((32'd1 << (hsize_i - 3'(DevSize))) - 32'd1) : '0;
                k     <= '0;
                state <= hsize_i > 3'(HostSize) ? ERR1 : DADDR;
            end else begin
                case (state)
                    DADDR: state <= DDATA;
                    DDATA: if (d_hreadyout_i) begin
                        if (d_hresp_i) state <= ERR1;
                        else begin
                            if (!write) rbuf <= rmerge;
                            if (!write && k == last) rdata <= rmerge;
                            k     <= k + KW'(1);
                            state <= k == last ? DONE : DADDR;
                        end
                    end
                    ERR1:    state <= ERR2;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign hreadyout_o = state == IDLE | state == DONE | state == ERR2;
    assign hresp_o     = state == ERR1 | state == ERR2;
    assign hrdata_o    = rdata;
    assign d_hsel_o    = state == DADDR;
    assign d_htrans_o  = d_hsel_o ? 2'b10 : 2'b00;
    assign d_haddr_o   = d_hsel_o ? beat_addr : '0;
    assign d_hsize_o   = d_hsel_o ? (multi ? 3'(DevSize) : size) : 3'd0;
    assign d_hwrite_o  = d_hsel_o & write;
    assign d_hwdata_o  = state == DDATA ? wdata[lane*DevDataWidth +: DevDataWidth] : '0;
    assign d_hready_o  = d_hreadyout_i;
endmodule

// File: tb/tb_ahb_downsizer.sv
// tb_ahb_downsizer: directed 64-on-32 scenarios with hand-computed expected values
module tb_ahb_downsizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [2:0]  hsize = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [63:0] hwdata = '0;
    logic        hready = 1'b1;
    logic        hreadyout_o;
    logic [63:0] hrdata_o;
    logic        hresp_o;
    logic        d_hsel_o;
    logic [31:0] d_haddr_o;
    logic [2:0]  d_hsize_o;
    logic [1:0]  d_htrans_o;
    logic        d_hwrite_o;
    logic [31:0] d_hwdata_o;
    logic        d_hready_o;
    logic [31:0] d_hrdata = '0;
    logic        d_hreadyout = 1'b1;
    logic        d_hresp = 1'b0;
    logic [38:0] dev;
    logic [38:0] want;
    int          vecs = 0;
    int          errs = 0;

    ahb_downsizer dut (
        .clk_i(clk), .rst_i(rst), .hsel_i(hsel), .haddr_i(haddr), .hsize_i(hsize),
        .htrans_i(htrans), .hwrite_i(hwrite), .hwdata_i(hwdata), .hready_i(hready),
        .hreadyout_o(hreadyout_o), .hrdata_o(hrdata_o), .hresp_o(hresp_o),
        .d_hsel_o(d_hsel_o), .d_haddr_o(d_haddr_o), .d_hsize_o(d_hsize_o),
        .d_htrans_o(d_htrans_o), .d_hwrite_o(d_hwrite_o), .d_hwdata_o(d_hwdata_o),
        .d_hready_o(d_hready_o), .d_hrdata_i(d_hrdata), .d_hreadyout_i(d_hreadyout),
        .d_hresp_i(d_hresp)
    );

    always #5 clk = ~clk;
    assign dev = {d_hsel_o, d_htrans_o, d_hwrite_o, d_hsize_o, d_haddr_o};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [2:0] s, input logic w);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = s; hwrite = w;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        vecs++; if ({hreadyout_o, hresp_o} !== 2'b10) begin errs++; $display("FAIL reset_host got %b want 10", {hreadyout_o, hresp_o}); end
        vecs++; if (hrdata_o !== 64'h0) begin errs++; $display("FAIL reset_hrdata got %h want 0", hrdata_o); end
        vecs++; if ({dev, d_hwdata_o} !== 71'h0) begin errs++; $display("FAIL reset_dev got %h want 0", {dev, d_hwdata_o}); end
        vecs++; if (d_hready_o !== 1'b1) begin errs++; $display("FAIL reset_dready got %b want 1", d_hready_o); end
    endtask

    task automatic test_read64;
        issue(32'h10, 3'd3, 1'b0);
        tick; htrans = 2'b00; d_hrdata = 32'hAAAA0000;
        want = {1'b1, 2'b10, 1'b0, 3'd2, 32'h10};
        vecs++; if (dev !== want) begin errs++; $display("FAIL rd64_beat0 got %h want %h", dev, want); end
        vecs++; if (hreadyout_o !== 1'b0) begin errs++; $display("FAIL rd64_c1_ready got %b want 0", hreadyout_o); end
        tick;
        vecs++; if (dev !== 39'h0) begin errs++; $display("FAIL rd64_ddata_dev got %h want 0", dev); end
        tick; d_hrdata = 32'hBBBB1111;
        want = {1'b1, 2'b10, 1'b0, 3'd2, 32'h14};
        vecs++; if (dev !== want) begin errs++; $display("FAIL rd64_beat1 got %h want %h", dev, want); end
        tick;
        vecs++; if (hreadyout_o !== 1'b0) begin errs++; $display("FAIL rd64_c4_ready got %b want 0", hreadyout_o); end
        tick;
        vecs++; if ({hreadyout_o, hresp_o} !== 2'b10) begin errs++; $display("FAIL rd64_done got %b want 10", {hreadyout_o, hresp_o}); end
        vecs++; if (hrdata_o !== 64'hBBBB1111AAAA0000) begin errs++; $display("FAIL rd64_data got %h want bbbb1111aaaa0000", hrdata_o); end
        tick;
    endtask

    task automatic test_write64;
        issue(32'h08, 3'd3, 1'b1);
        tick; htrans = 2'b00; hwdata = 64'h1234567899AABBCC;
        want = {1'b1, 2'b10, 1'b1, 3'd2, 32'h08};
        vecs++; if (dev !== want) begin errs++; $display("FAIL wr64_beat0 got %h want %h", dev, want); end
        tick; hwdata = 64'hFFFFFFFFFFFFFFFF;
        vecs++; if (d_hwdata_o !== 32'h99AABBCC) begin errs++; $display("FAIL wr64_data0 got %h want 99aabbcc", d_hwdata_o); end
        tick;
        want = {1'b1, 2'b10, 1'b1, 3'd2, 32'h0C};
        vecs++; if (dev !== want) begin errs++; $display("FAIL wr64_beat1 got %h want %h", dev, want); end
        tick;
        vecs++; if (d_hwdata_o !== 32'h12345678) begin errs++; $display("FAIL wr64_data1 got %h want 12345678", d_hwdata_o); end
        tick;
        vecs++; if (hreadyout_o !== 1'b1) begin errs++; $display("FAIL wr64_done got %b want 1", hreadyout_o); end
        vecs++; if (hrdata_o !== 64'hBBBB1111AAAA0000) begin errs++; $display("FAIL wr64_hold got %h want bbbb1111aaaa0000", hrdata_o); end
        tick;
    endtask

    task automatic test_single;
        issue(32'h14, 3'd2, 1'b0);
        tick; htrans = 2'b00; d_hrdata = 32'hCAFEF00D;
        want = {1'b1, 2'b10, 1'b0, 3'd2, 32'h14};
        vecs++; if (dev !== want) begin errs++; $display("FAIL rd32_addr got %h want %h", dev, want); end
        tick; tick;
        vecs++; if (hreadyout_o !== 1'b1) begin errs++; $display("FAIL rd32_done got %b want 1", hreadyout_o); end
        vecs++; if (hrdata_o !== 64'hCAFEF00DCAFEF00D) begin errs++; $display("FAIL rd32_repl got %h want cafef00dcafef00d", hrdata_o); end
        tick;
        issue(32'h14, 3'd2, 1'b1);
        tick; htrans = 2'b00; hwdata = 64'h5566778811223344;
        tick;
        vecs++; if (d_hwdata_o !== 32'h55667788) begin errs++; $display("FAIL wr32_hi got %h want 55667788", d_hwdata_o); end
        tick; tick;
        issue(32'h10, 3'd2, 1'b1);
        tick; htrans = 2'b00;
        tick;
        vecs++; if (d_hwdata_o !== 32'h11223344) begin errs++; $display("FAIL wr32_lo got %h want 11223344", d_hwdata_o); end
        tick; tick;
        issue(32'h16, 3'd0, 1'b1);
        tick; htrans = 2'b00;
        want = {1'b1, 2'b10, 1'b1, 3'd0, 32'h16};
        vecs++; if (dev !== want) begin errs++; $display("FAIL wr8_addr got %h want %h", dev, want); end
        tick;
        vecs++; if (d_hwdata_o !== 32'h55667788) begin errs++; $display("FAIL wr8_lane got %h want 55667788", d_hwdata_o); end
        tick; tick;
    endtask

    task automatic test_back_to_back;
        int low = 0;
        issue(32'h20, 3'd3, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick;
            htrans = 2'b00;
            if (hreadyout_o) break;
            low++;
            d_hreadyout = !(i == 4 || i == 5);
            d_hrdata = i < 3 ? 32'h1 : 32'h2;
        end
        d_hreadyout = 1'b1;
        vecs++; if (low !== 6) begin errs++; $display("FAIL wait_low_cycles got %0d want 6", low); end
        vecs++; if (hrdata_o !== 64'h0000000200000001) begin errs++; $display("FAIL wait_data got %h want 0000000200000001", hrdata_o); end
        issue(32'h30, 3'd2, 1'b1);
        tick; htrans = 2'b00; hwdata = 64'hDEAD0000BEEF1111;
        want = {1'b1, 2'b10, 1'b1, 3'd2, 32'h30};
        vecs++; if (dev !== want) begin errs++; $display("FAIL b2b_daddr got %h want %h", dev, want); end
        tick;
        vecs++; if (d_hwdata_o !== 32'hBEEF1111) begin errs++; $display("FAIL b2b_wdata got %h want beef1111", d_hwdata_o); end
        tick;
        vecs++; if (hreadyout_o !== 1'b1) begin errs++; $display("FAIL b2b_done got %b want 1", hreadyout_o); end
        tick;
    endtask

    task automatic test_dev_error;
        issue(32'h40, 3'd3, 1'b1);
        tick; htrans = 2'b00; hwdata = 64'h0123456789ABCDEF;
        tick; d_hreadyout = 1'b0; d_hresp = 1'b1;
        tick; d_hreadyout = 1'b1;
        tick; d_hresp = 1'b0;
        vecs++; if ({hresp_o, hreadyout_o, d_hsel_o} !== 3'b100) begin errs++; $display("FAIL err_err1 got %b want 100", {hresp_o, hreadyout_o, d_hsel_o}); end
        tick;
        vecs++; if ({hresp_o, hreadyout_o, d_hsel_o} !== 3'b110) begin errs++; $display("FAIL err_err2 got %b want 110", {hresp_o, hreadyout_o, d_hsel_o}); end
        tick;
        vecs++; if ({hresp_o, hreadyout_o, d_hsel_o} !== 3'b010) begin errs++; $display("FAIL err_idle got %b want 010", {hresp_o, hreadyout_o, d_hsel_o}); end
    endtask

    task automatic test_oversize_reset;
        tick;
        vecs++; if ({hresp_o, hreadyout_o, d_hsel_o} !== 3'b010) begin errs++; $display("FAIL idle_xfer got %b want 010", {hresp_o, hreadyout_o, d_hsel_o}); end
        issue(32'h0, 3'd4, 1'b0);
        tick; htrans = 2'b00;
        vecs++; if ({hresp_o, hreadyout_o, d_hsel_o} !== 3'b100) begin errs++; $display("FAIL ovs_err1 got %b want 100", {hresp_o, hreadyout_o, d_hsel_o}); end
        tick;
        vecs++; if ({hresp_o, hreadyout_o, d_hsel_o} !== 3'b110) begin errs++; $display("FAIL ovs_err2 got %b want 110", {hresp_o, hreadyout_o, d_hsel_o}); end
        tick;
        vecs++; if ({hresp_o, hreadyout_o, d_hsel_o} !== 3'b010) begin errs++; $display("FAIL ovs_idle got %b want 010", {hresp_o, hreadyout_o, d_hsel_o}); end
        issue(32'h50, 3'd3, 1'b1);
        tick; htrans = 2'b00; hwdata = 64'h0F0F0F0FA5A5A5A5;
        tick;
        vecs++; if (d_hwdata_o !== 32'hA5A5A5A5) begin errs++; $display("FAIL rst_pre_data got %h want a5a5a5a5", d_hwdata_o); end
        rst = 1'b1;
        tick; rst = 1'b0;
        vecs++; if ({hreadyout_o, hresp_o} !== 2'b10) begin errs++; $display("FAIL rst_mid_host got %b want 10", {hreadyout_o, hresp_o}); end
        vecs++; if (hrdata_o !== 64'h0) begin errs++; $display("FAIL rst_mid_hrdata got %h want 0", hrdata_o); end
        vecs++; if ({dev, d_hwdata_o} !== 71'h0) begin errs++; $display("FAIL rst_mid_dev got %h want 0", {dev, d_hwdata_o}); end
        tick;
    endtask

    initial begin
        test_reset;
        test_read64;
        test_write64;
        test_single;
        test_back_to_back;
        test_dev_error;
        test_oversize_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
